// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_arb registered multiplexer/arbiter.
package mux_arb_pkg;

  // Grant mode: fixed channel select or round-robin arbitration.
  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_t;

  // Width of the optional output-handshake counter.
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: owns the "last granted" pointer and produces a one-hot
// grant scanning last+1, last+2, ... modulo N. The pointer moves only on advance.
module rr_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [SELW-1:0] last;

  // Pick the first requester after the previous winner.
  always_comb begin
    int unsigned     pos;
    logic [SELW-1:0] pos_s;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    pos_s   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos   = (int'(last) + k) % N;
      pos_s = SELW'(pos);
      if (!gnt_any && req[pos_s]) begin
        gnt_any    = 1'b1;
        gnt_idx    = pos_s;
        gnt[pos_s] = 1'b1;
      end
    end
  end

  // Pointer register; reset to N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SELW'(N - 1);
    end else if (advance && gnt_any) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel, W-bit registered multiplexer with valid/ready on every port.
// Grants by fixed sel (MODE_SEL) or round-robin (MODE_RR).
// Optional: define MUX_ARB_CNT_EN to add the saturating xfer_cnt port.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  mode_t           mode_e;
  logic            load_c;
  logic            xfer_c;
  logic            advance_c;

  logic [N-1:0]    rr_gnt;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;

  logic [N-1:0]    sel_gnt;
  logic [SELW-1:0] sel_idx;
  logic            sel_any;

  logic [N-1:0]    gnt_oh;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    gnt_data;

  assign mode_e    = mode_t'(mode);
  // Output register can take a new beat when empty or draining this cycle.
  assign load_c    = !out_valid || out_ready;
  assign xfer_c    = gnt_any && load_c && !rst;
  assign advance_c = xfer_c && (mode_e == MODE_RR);
  assign in_ready  = xfer_c ? gnt_oh : '0;

  rr_arb #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (advance_c),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Fixed-select grant; an out-of-range sel matches no channel.
  always_comb begin
    sel_gnt = '0;
    sel_idx = '0;
    sel_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SELW'(i) == sel && in_valid[i]) begin
        sel_gnt[i] = 1'b1;
        sel_idx    = SELW'(i);
        sel_any    = 1'b1;
      end
    end
  end

  // Choose the grant source by mode.
  always_comb begin
    gnt_oh  = sel_gnt;
    gnt_idx = sel_idx;
    gnt_any = sel_any;
    if (mode_e == MODE_RR) begin
      gnt_oh  = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SELW'(i) == gnt_idx) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // Output register: load on transfer, clear valid on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_CNT_EN
  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != {CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb (N=4 main instance, N=3 out-of-range sel instance).
module tb_mux_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, mode, out_ready, out_valid;
  logic [1:0]     sel, out_chan;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
`ifdef MUX_ARB_CNT_EN
  logic [15:0]    xfer_cnt;
  logic [15:0]    xfer_cnt3;
`endif

  logic           rst3, mode3, out_ready3, out_valid3;
  logic [1:0]     sel3, out_chan3;
  logic [23:0]    in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [7:0]     out_data3;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_last;
  logic        m_ov;
  logic [7:0]  m_od;
  int          m_oc;
  int unsigned m_cnt;
  logic [3:0]  seen_ready;

  always #5 clk = ~clk;

  mux_arb #(.N(4), .W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_ARB_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  mux_arb #(.N(3), .W(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef MUX_ARB_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Grant rule: sel channel if in range and valid; else first valid after last.
  function automatic int ref_grant(input logic m, input int s, input logic [3:0] v, input int last);
    logic [3:0] t;
    int         c;
    if (m == 1'b0) begin
      if (s >= N) return -1;
      t = v >> s;
      return t[0] ? s : -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      t = v >> c;
      if (t[0]) return c;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic r, input logic m, input logic [1:0] s,
                      input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int         g;
    logic [3:0] er;
    @(negedge clk);
    rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g  = r ? -1 : ref_grant(m, int'(s), v, m_last);
    er = '0;
    if (g >= 0 && (!m_ov || ordy)) er = 4'(1 << g);
    seen_ready = in_ready;
    check("in_ready",  32'(in_ready),  32'(er));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_chan",  32'(out_chan),  32'(m_oc));
`ifdef MUX_ARB_CNT_EN
    check("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
`endif
    @(posedge clk);
    if (r) begin
      m_ov = 1'b0; m_od = '0; m_oc = 0; m_last = N - 1; m_cnt = 0;
    end else begin
      if (m_ov && ordy && m_cnt < 32'hFFFF) m_cnt++;
      if (g >= 0 && (!m_ov || ordy)) begin
        m_ov = 1'b1;
        m_od = 8'(d >> (8 * g));
        m_oc = g;
        if (m) m_last = g;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] d;
    m_last = N - 1; m_ov = 1'b0; m_od = '0; m_oc = 0; m_cnt = 0;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);

    // in_ready stays low during reset even with valid inputs
    step(1'b1, 1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1);
    check("rst_ready", 32'(seen_ready), 32'h0);

    // Fixed select of channel 2
    step(1'b0, 1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1);
    check("sel_ready", 32'(seen_ready), 32'h4);
    check("sel_data",  32'(out_data),   32'hA5);
    check("sel_chan",  32'(out_chan),   32'd2);
    check("sel_valid", 32'(out_valid),  32'd1);

    // Round-robin, all valid, full throughput
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      step(1'b0, 1'b1, 2'd0, 4'hF, d, 1'b1);
      check("rr_seq",   32'(out_chan),  32'(k % 4));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure holds channel 1, then channel 3 wins
    step(1'b0, 1'b1, 2'd0, 4'b1010, 32'h44332211, 1'b1);
    check("bp_first", 32'(out_chan), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'd0, 4'b1010, $urandom, 1'b0);
      check("bp_ready", 32'(seen_ready), 32'h0);
      check("bp_chan",  32'(out_chan),   32'd1);
      check("bp_data",  32'(out_data),   32'h22);
    end
    step(1'b0, 1'b1, 2'd0, 4'b1010, 32'h44332211, 1'b1);
    check("bp_next",  32'(seen_ready), 32'h8);
    check("bp_chan3", 32'(out_chan),   32'd3);

    // Reset while a beat is stalled
    step(1'b0, 1'b1, 2'd0, 4'b0000, 32'h0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b0000, 32'h0, 1'b0);
    check("rst_drop", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1);
    check("rst_rr0", 32'(seen_ready), 32'h1);

`ifdef MUX_ARB_CNT_EN
    // Counter: five handshakes, then saturation
    step(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    check("cnt5", 32'(xfer_cnt), 32'd5);
    @(negedge clk);
    u_dut.xfer_cnt = 16'hFFFE;
    m_cnt = 32'hFFFE;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
`endif

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
           $urandom, ($urandom_range(0, 3) != 0));
    end

    // N=3: out-of-range sel grants nothing, then sel=1 transfers
    @(negedge clk);
    rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = 24'h332211; out_ready3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("n3_ready_oor", 32'(in_ready3), 32'h0);
    @(posedge clk);
    #1;
    check("n3_valid_oor", 32'(out_valid3), 32'd0);
    @(negedge clk);
    sel3 = 2'd1;
    #1;
    check("n3_ready_sel1", 32'(in_ready3), 32'h2);
    @(posedge clk);
    #1;
    check("n3_valid", 32'(out_valid3), 32'd1);
    check("n3_chan",  32'(out_chan3),  32'd1);
    check("n3_data",  32'(out_data3),  32'h22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
